// File: rtl/avl_mem_arbiter.sv
// ---------------------------------------------------------------------------
// avl_mem_arbiter
//   Shares one DDR3 controller Avalon port among N_MASTERS buffer units.
//   Masters request by raising read or write. Grant is round-robin starting
//   at rr_ptr, with a bounded hold of MAX_HOLD accepted commands per tenure.
//   Every accepted read pushes the owner index into an in-order tag FIFO, so
//   returning read data is steered to the master that issued it, even after
//   the grant has moved on.
//
// Ports (master i occupies slice [i*W +: W] of every flattened vector):
//   iCLK, iRST              clock, synchronous active-high reset
//   m_avl_read/write        per-master command request
//   m_avl_burstbegin        per-master burstbegin
//   m_avl_address           per-master address            (N_MASTERS*ADDR_W)
//   m_avl_writedata         per-master write data         (N_MASTERS*DATA_W)
//   m_avl_wait_request_n    per-master command accept (0 unless owner)
//   m_avl_readdatavalid     per-master routed read-valid
//   m_avl_readdata          read data broadcast to all masters
//   m_local_init_done       replicated ddr_local_init_done
//   ddr_avl_*               command/status port of the DDR3 controller
//   oRD_ERR                 sticky: readdatavalid arrived with no tag pending
//   oGRANT / oGRANT_VALID   current owner index / owner valid (debug)
// ---------------------------------------------------------------------------
module avl_mem_arbiter #(
   parameter int N_MASTERS = 4,
   parameter int ADDR_W    = 26,
   parameter int DATA_W    = 128,
   parameter int MAX_HOLD  = 8,
   parameter int RD_DEPTH  = 16
) (
   input  logic                          iCLK,
   input  logic                          iRST,
   input  logic [N_MASTERS-1:0]          m_avl_read,
   input  logic [N_MASTERS-1:0]          m_avl_write,
   input  logic [N_MASTERS-1:0]          m_avl_burstbegin,
   input  logic [N_MASTERS*ADDR_W-1:0]   m_avl_address,
   input  logic [N_MASTERS*DATA_W-1:0]   m_avl_writedata,
   output logic [N_MASTERS-1:0]          m_avl_wait_request_n,
   output logic [N_MASTERS-1:0]          m_avl_readdatavalid,
   output logic [DATA_W-1:0]             m_avl_readdata,
   output logic [N_MASTERS-1:0]          m_local_init_done,
   output logic                          ddr_avl_read,
   output logic                          ddr_avl_write,
   output logic                          ddr_avl_burstbegin,
   output logic [ADDR_W-1:0]             ddr_avl_address,
   output logic [DATA_W-1:0]             ddr_avl_writedata,
   input  logic                          ddr_avl_wait_request_n,
   input  logic                          ddr_avl_readdatavalid,
   input  logic                          ddr_local_init_done,
   input  logic [DATA_W-1:0]             ddr_avl_readdata,
   output logic                          oRD_ERR,
   output logic [$clog2(N_MASTERS)-1:0]  oGRANT,
   output logic                          oGRANT_VALID
);

   localparam int GW = $clog2(N_MASTERS);
   localparam int PW = $clog2(RD_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic {ST_IDLE, ST_OWN} state_t;

   // Arbitration state
   state_t          r_state;
   logic [GW-1:0]   r_grant;
   logic [GW-1:0]   r_rr_ptr;
   logic [7:0]      r_hold_cnt;

   // Return-tag FIFO
   logic [GW-1:0]   r_tag_mem [RD_DEPTH];
   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;
   logic            r_rd_err;

   logic [N_MASTERS-1:0] w_req;
   logic            w_own;
   logic            w_own_rd;
   logic            w_own_wr;
   logic            w_full;
   logic            w_stall;
   logic            w_wrn_eff;
   logic            w_accept;
   logic            w_push;
   logic            w_pop;
   logic            w_spurious;
   logic            w_last_hold;
   logic            w_pick_valid;
   logic [GW-1:0]   w_pick;
   logic [GW-1:0]   w_cand;
   logic [GW-1:0]   w_grant_next;

   assign w_req       = m_avl_read | m_avl_write;
   assign w_own       = (r_state == ST_OWN);
   assign w_own_rd    = w_own & m_avl_read[r_grant];
   assign w_own_wr    = w_own & m_avl_write[r_grant];
   assign w_full      = (r_count == CW'(RD_DEPTH));
   // A full tag FIFO stalls only reads; it is not relieved by a same-cycle pop.
   assign w_stall     = w_own_rd & w_full;
   assign w_wrn_eff   = ddr_avl_wait_request_n & ~w_stall;
   assign w_accept    = (w_own_rd | w_own_wr) & w_wrn_eff;
   // Read wins over a simultaneous (illegal) write, so any accepted read pushes.
   assign w_push      = w_accept & w_own_rd;
   assign w_pop       = ddr_avl_readdatavalid & (r_count != '0);
   assign w_spurious  = ddr_avl_readdatavalid & (r_count == '0);
   assign w_last_hold = (r_hold_cnt == 8'(MAX_HOLD - 1));
   assign w_grant_next = (r_grant == GW'(N_MASTERS - 1)) ? '0 : r_grant + 1'b1;

   // Round-robin pick: first requester at or after rr_ptr, with wrap.
   // Walking offsets downward lets the smallest offset overwrite the others.
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can
      // leave it unassigned and infer a latch.
      w_pick_valid = 1'b0;
      w_pick       = '0;
      w_cand       = '0;
      for (int k = N_MASTERS - 1; k >= 0; k--) begin
         w_cand = GW'((int'(r_rr_ptr) + k) % N_MASTERS);
         if (w_req[w_cand]) begin
            w_pick_valid = 1'b1;
            w_pick       = w_cand;
         end
      end
   end

   // Command path: the owner is forwarded combinationally, everything else
   // is held at zero.
   always_comb begin
      ddr_avl_read         = 1'b0;
      ddr_avl_write        = 1'b0;
      ddr_avl_burstbegin   = 1'b0;
      ddr_avl_address      = '0;
      ddr_avl_writedata    = '0;
      m_avl_wait_request_n = '0;
      if (w_own) begin
         ddr_avl_read         = w_own_rd & ~w_full;
         ddr_avl_write        = w_own_wr & ~w_own_rd;
         ddr_avl_burstbegin   = m_avl_burstbegin[r_grant];
         ddr_avl_address      = m_avl_address[int'(r_grant)*ADDR_W +: ADDR_W];
         ddr_avl_writedata    = m_avl_writedata[int'(r_grant)*DATA_W +: DATA_W];
         m_avl_wait_request_n[r_grant] = w_wrn_eff;
      end
   end

   // Read return: the FIFO head selects which master sees the valid.
   always_comb begin
      m_avl_readdatavalid = '0;
      if (w_pop) begin
         m_avl_readdatavalid[r_tag_mem[r_rd_ptr]] = 1'b1;
      end
   end

   assign m_avl_readdata    = ddr_avl_readdata;
   assign m_local_init_done = {N_MASTERS{ddr_local_init_done}};
   assign oRD_ERR           = r_rd_err;
   assign oGRANT            = r_grant;
   assign oGRANT_VALID      = w_own;

   // Grant FSM. Release happens when the owner goes quiet or when the
   // MAX_HOLD-th command of the tenure is accepted.
   always_ff @(posedge iCLK) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (iRST) begin
         r_state    <= ST_IDLE;
         r_grant    <= '0;
         r_rr_ptr   <= '0;
         r_hold_cnt <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (ddr_local_init_done && w_pick_valid) begin
                  r_grant    <= w_pick;
                  r_hold_cnt <= '0;
                  r_state    <= ST_OWN;
               end
            end
            ST_OWN: begin
               if (!w_own_rd && !w_own_wr) begin
                  r_state  <= ST_IDLE;
                  r_rr_ptr <= w_grant_next;
               end else if (w_accept) begin
                  if (w_last_hold) begin
                     r_state  <= ST_IDLE;
                     r_rr_ptr <= w_grant_next;
                  end else begin
                     r_hold_cnt <= r_hold_cnt + 8'd1;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Tag FIFO control and the sticky spurious-return flag.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_rd_err <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (w_spurious) r_rd_err <= 1'b1;
      end
   end

   // NOTE: the tag storage has no reset; entries are only ever read after
   // being written, because the count gates every pop.
   always_ff @(posedge iCLK) begin
      if (w_push) r_tag_mem[r_wr_ptr] <= r_grant;
   end

endmodule

// File: tb/tb_avl_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_avl_mem_arbiter
//   Directed scenarios (init gating, round-robin, out-of-grant return, FIFO
//   full, spurious return, reset mid-burst) followed by random traffic. Every
//   cycle is compared against a transaction-level reference model (owner
//   index, hold count, round-robin pointer and a queue of pending read tags).
// ---------------------------------------------------------------------------
module tb_avl_mem_arbiter;

   localparam int N  = 4;
   localparam int AW = 16;
   localparam int DW = 32;
   localparam int MH = 2;
   localparam int RD = 4;
   localparam int GW = $clog2(N);

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    m_avl_read, m_avl_write, m_avl_burstbegin;
   logic [N*AW-1:0] m_avl_address;
   logic [N*DW-1:0] m_avl_writedata;
   logic [N-1:0]    m_avl_wait_request_n, m_avl_readdatavalid, m_local_init_done;
   logic [DW-1:0]   m_avl_readdata;
   logic            ddr_avl_read, ddr_avl_write, ddr_avl_burstbegin;
   logic [AW-1:0]   ddr_avl_address;
   logic [DW-1:0]   ddr_avl_writedata;
   logic            ddr_avl_wait_request_n, ddr_avl_readdatavalid, ddr_local_init_done;
   logic [DW-1:0]   ddr_avl_readdata;
   logic            oRD_ERR;
   logic [GW-1:0]   oGRANT;
   logic            oGRANT_VALID;

   always #5 clk = ~clk;

   avl_mem_arbiter #(
      .N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH), .RD_DEPTH(RD)
   ) dut (
      .iCLK(clk), .iRST(rst),
      .m_avl_read(m_avl_read), .m_avl_write(m_avl_write),
      .m_avl_burstbegin(m_avl_burstbegin), .m_avl_address(m_avl_address),
      .m_avl_writedata(m_avl_writedata),
      .m_avl_wait_request_n(m_avl_wait_request_n),
      .m_avl_readdatavalid(m_avl_readdatavalid),
      .m_avl_readdata(m_avl_readdata), .m_local_init_done(m_local_init_done),
      .ddr_avl_read(ddr_avl_read), .ddr_avl_write(ddr_avl_write),
      .ddr_avl_burstbegin(ddr_avl_burstbegin), .ddr_avl_address(ddr_avl_address),
      .ddr_avl_writedata(ddr_avl_writedata),
      .ddr_avl_wait_request_n(ddr_avl_wait_request_n),
      .ddr_avl_readdatavalid(ddr_avl_readdatavalid),
      .ddr_local_init_done(ddr_local_init_done),
      .ddr_avl_readdata(ddr_avl_readdata),
      .oRD_ERR(oRD_ERR), .oGRANT(oGRANT), .oGRANT_VALID(oGRANT_VALID)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   int mo;        // owner index, -1 when no owner
   int mrr;       // round-robin start
   int mhold;     // accepted commands in this tenure
   int mq[$];     // pending read tags, oldest first
   bit merr;

   // Values sampled from the DUT in the most recent step()
   logic [N-1:0]  s_wrn, s_rdv;
   logic          s_ddr_read, s_ddr_write, s_gv, s_err;
   logic [GW-1:0] s_grant;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mo = -1; mrr = 0; mhold = 0; mq.delete(); merr = 1'b0;
   endtask

   task automatic idle_inputs();
      m_avl_read = '0; m_avl_write = '0; m_avl_burstbegin = '0;
      m_avl_address = '0; m_avl_writedata = '0;
      ddr_avl_wait_request_n = 1'b1; ddr_avl_readdatavalid = 1'b0;
      ddr_local_init_done = 1'b1; ddr_avl_readdata = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      @(posedge clk); #1;
      model_reset();
      rst = 1'b0;
   endtask

   // One clock cycle: compare all outputs mid-cycle, then advance the model.
   task automatic step();
      bit own, rd, wr, full, wrn_eff, accept;
      logic [N-1:0]  e_wrn, e_rdv;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wdata;
      logic          e_bb;
      @(negedge clk);
      own = (mo >= 0);
      rd = 1'b0; wr = 1'b0; e_bb = 1'b0; e_addr = '0; e_wdata = '0;
      if (own) begin
         rd = m_avl_read[mo]; wr = m_avl_write[mo]; e_bb = m_avl_burstbegin[mo];
         e_addr = m_avl_address[mo*AW +: AW]; e_wdata = m_avl_writedata[mo*DW +: DW];
      end
      full    = (mq.size() == RD);
      wrn_eff = ddr_avl_wait_request_n && !(rd && full);
      e_wrn   = '0;
      if (own) e_wrn[mo] = wrn_eff;
      accept  = own && (rd || wr) && wrn_eff;
      e_rdv   = '0;
      if (ddr_avl_readdatavalid && mq.size() > 0) e_rdv[mq[0]] = 1'b1;

      s_wrn = m_avl_wait_request_n; s_rdv = m_avl_readdatavalid;
      s_ddr_read = ddr_avl_read; s_ddr_write = ddr_avl_write;
      s_gv = oGRANT_VALID; s_grant = oGRANT; s_err = oRD_ERR;

      check("ddr_read",    64'(ddr_avl_read),         64'(rd && !full));
      check("ddr_write",   64'(ddr_avl_write),        64'(wr && !rd));
      check("ddr_bb",      64'(ddr_avl_burstbegin),   64'(e_bb));
      check("ddr_addr",    64'(ddr_avl_address),      64'(e_addr));
      check("ddr_wdata",   64'(ddr_avl_writedata),    64'(e_wdata));
      check("wait_req_n",  64'(m_avl_wait_request_n), 64'(e_wrn));
      check("rdv",         64'(m_avl_readdatavalid),  64'(e_rdv));
      check("readdata",    64'(m_avl_readdata),       64'(ddr_avl_readdata));
      check("init_done",   64'(m_local_init_done),    64'({N{ddr_local_init_done}}));
      check("rd_err",      64'(oRD_ERR),              64'(merr));
      check("grant_valid", 64'(oGRANT_VALID),         64'(own));
      if (own) check("grant", 64'(oGRANT), 64'(mo));

      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         if (ddr_avl_readdatavalid) begin
            if (mq.size() > 0) void'(mq.pop_front());
            else merr = 1'b1;
         end
         if (accept && rd) mq.push_back(mo);
         if (own) begin
            if (!rd && !wr) begin
               mrr = (mo + 1) % N; mo = -1;
            end else if (accept) begin
               mhold++;
               if (mhold == MH) begin mrr = (mo + 1) % N; mo = -1; end
            end
         end else if (ddr_local_init_done && ((m_avl_read | m_avl_write) != '0)) begin
            for (int k = 0; k < N; k++) begin
               if (mo < 0 && (m_avl_read[(mrr + k) % N] || m_avl_write[(mrr + k) % N]))
                  mo = (mrr + k) % N;
            end
            mhold = 0;
         end
      end
      #1;
   endtask

   initial begin
      int acc_m[$];
      int acc_c[$];
      int exp_m[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
      int exp_c[10] = '{1, 2, 4, 5, 7, 8, 10, 11, 13, 14};
      logic [N-1:0] exp_ret[4] = '{4'b0100, 4'b0100, 4'b0100, 4'b0001};
      logic [N-1:0] ret[$];
      int n0, n2, acc;
      bit hit;

      // ---- reset state ----
      do_reset();
      step();
      check("reset_gv",    64'(s_gv),        64'(0));
      check("reset_grant", 64'(s_grant),     64'(0));
      check("reset_wrn",   64'(s_wrn),       64'(0));
      check("reset_rd",    64'(s_ddr_read),  64'(0));
      check("reset_err",   64'(s_err),       64'(0));

      // ---- init gating ----
      do_reset();
      ddr_local_init_done = 1'b0; ddr_avl_wait_request_n = 1'b0;
      m_avl_read[1] = 1'b1;
      for (int cyc = 0; cyc < 12; cyc++) begin
         if (cyc == 10) ddr_local_init_done = 1'b1;
         step();
         if (cyc < 11) check("init_gate_rd", 64'(s_ddr_read), 64'(0));
      end
      check("init_rd_11",    64'(s_ddr_read), 64'(1));
      check("init_grant_11", 64'(s_grant),    64'(1));

      // ---- round-robin, MAX_HOLD=2 ----
      do_reset();
      m_avl_read = '1;
      for (int cyc = 0; cyc < 16; cyc++) begin
         ddr_avl_readdatavalid = (mq.size() > 0);
         step();
         for (int i = 0; i < N; i++)
            if (s_wrn[i] && s_ddr_read) begin acc_m.push_back(i); acc_c.push_back(cyc); end
      end
      for (int i = 0; i < 10; i++) begin
         check("rr_master", 64'(i < acc_m.size() ? acc_m[i] : -1), 64'(exp_m[i]));
         check("rr_cycle",  64'(i < acc_c.size() ? acc_c[i] : -1), 64'(exp_c[i]));
      end

      // ---- out-of-grant return ----
      do_reset();
      n0 = 0; n2 = 0;
      m_avl_read[2] = 1'b1;
      for (int cyc = 0; cyc < 40 && n0 < 1; cyc++) begin
         step();
         if (s_wrn[2] && s_ddr_read) n2++;
         if (s_wrn[0] && s_ddr_read) n0++;
         m_avl_read[2] = (n2 < 3);
         m_avl_read[0] = (n2 >= 3 && n0 < 1);
      end
      m_avl_read = '0;
      check("oog_n2", 64'(n2), 64'(3));
      check("oog_n0", 64'(n0), 64'(1));
      repeat (20) step();
      for (int i = 0; i < 4; i++) begin
         ddr_avl_readdatavalid = 1'b1;
         ddr_avl_readdata = DW'($urandom);
         step();
         ret.push_back(s_rdv);
      end
      ddr_avl_readdatavalid = 1'b0;
      for (int i = 0; i < 4; i++) check("oog_ret", 64'(ret[i]), 64'(exp_ret[i]));

      // ---- FIFO full ----
      do_reset();
      acc = 0;
      m_avl_read[0] = 1'b1;
      for (int cyc = 0; cyc < 14; cyc++) begin
         step();
         if (s_wrn[0] && s_ddr_read) acc++;
      end
      check("full_acc",   64'(acc),        64'(4));
      check("full_wrn",   64'(s_wrn),      64'(0));
      check("full_rd",    64'(s_ddr_read), 64'(0));
      check("full_gv",    64'(s_gv),       64'(1));
      ddr_avl_readdatavalid = 1'b1;
      step();
      check("full_pop_rdv", 64'(s_rdv), 64'(4'b0001));
      check("full_pop_wrn", 64'(s_wrn), 64'(0));
      ddr_avl_readdatavalid = 1'b0;
      step();
      check("full_5th_wrn", 64'(s_wrn),      64'(4'b0001));
      check("full_5th_rd",  64'(s_ddr_read), 64'(1));
      m_avl_read = '0;

      // ---- spurious return ----
      do_reset();
      ddr_avl_readdatavalid = 1'b1;
      step();
      check("spur_rdv", 64'(s_rdv), 64'(0));
      ddr_avl_readdatavalid = 1'b0;
      repeat (3) begin
         step();
         check("spur_err_held", 64'(s_err), 64'(1));
      end
      do_reset();
      step();
      check("spur_err_clr", 64'(s_err), 64'(0));

      // ---- reset mid-burst ----
      do_reset();
      hit = 1'b0;
      m_avl_read[1] = 1'b1;
      for (int cyc = 0; cyc < 10 && !hit; cyc++) begin
         step();
         hit = s_wrn[1] && s_ddr_read;
      end
      check("mid_m1_acc", 64'(hit), 64'(1));
      m_avl_read = '0;
      m_avl_write[3] = 1'b1;
      m_avl_writedata[3*DW +: DW] = DW'($urandom);
      hit = 1'b0;
      for (int cyc = 0; cyc < 10 && !hit; cyc++) begin
         step();
         hit = s_gv && (s_grant == 2'd3) && s_ddr_write;
      end
      check("mid_m3_own", 64'(hit), 64'(1));
      rst = 1'b1;
      step();
      rst = 1'b0;
      m_avl_read[1] = 1'b1;
      ddr_avl_readdatavalid = 1'b1;
      step();
      check("mid_wr_drop", 64'(s_ddr_write), 64'(0));
      check("mid_gv_drop", 64'(s_gv),        64'(0));
      check("mid_flush",   64'(s_rdv),       64'(0));
      ddr_avl_readdatavalid = 1'b0;
      step();
      check("mid_rr0_grant", 64'(s_grant), 64'(1));
      check("mid_err",       64'(s_err),   64'(1));

      // ---- random traffic against the model ----
      do_reset();
      for (int cyc = 0; cyc < 600; cyc++) begin
         for (int i = 0; i < N; i++) begin
            int r;
            r = $urandom_range(0, 19);
            m_avl_read[i]  = (r < 7) || (r == 19);
            m_avl_write[i] = (r >= 7 && r < 11) || (r == 19);
            m_avl_burstbegin[i] = 1'($urandom_range(0, 1));
         end
         m_avl_address   = {N{AW'($urandom)}} ^ (N*AW)'($urandom);
         m_avl_writedata = {N{DW'($urandom)}} ^ (N*DW)'($urandom);
         ddr_avl_wait_request_n = ($urandom_range(0, 3) != 0);
         ddr_local_init_done    = ($urandom_range(0, 15) != 0);
         ddr_avl_readdatavalid  = (mq.size() > 0) ? ($urandom_range(0, 2) == 0)
                                                  : ($urandom_range(0, 40) == 0);
         ddr_avl_readdata = DW'($urandom);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
